spm_seq_ctrl: RTL and testbench
===============================

// Module: spm_seq_ctrl
// PURPOSE
//   Sequencer for the serial-parallel multiplier (spm) array of csa cells.
//   Accepts a multiplicand/multiplier pair over a valid/ready handshake and latches x.
//   Clears the csa carry/sum state, streams y bits LSB-first, and deserialises the
//   product bits from spm. Presents the 2*WIDTH-bit product over a valid/ready handshake.
// PARAMETERS
//   WIDTH   32  operand width; equals the spm x width (one csa cell per bit)
//   P_LAT   1   cycles from driving y bit k to spm p showing product bit k
//   SIGNED  0   1: y bits WIDTH..2*WIDTH-1 = b_in[WIDTH-1] (sign ext); 0: zero
// PORTS
//   clk          in   1          clock, rising edge
//   rst          in   1          synchronous reset, active-low
//   start_valid  in   1          operand pair offered
//   start_ready  out  1          operand pair accepted when start_valid && start_ready
//   a_in         in   WIDTH      multiplicand (parallel x)
//   b_in         in   WIDTH      multiplier (serialised onto y)
//   spm_x        out  WIDTH      parallel x to spm; held from accept through DONE
//   spm_y        out  1          serial y bit to spm
//   spm_rst      out  1          active-low clear to spm csa flops
//   spm_p        in   1          serial product bit from spm
//   prod         out  2*WIDTH    product, valid while prod_valid
//   prod_valid   out  1          product available
//   prod_ready   in   1          product consumed when prod_valid && prod_ready
//   busy         out  1          state != IDLE
// BEHAVIOUR
//   Reset (rst==0 at edge): state=IDLE; start_ready=1, prod_valid=0, busy=0,
//     spm_y=0, spm_x=0, prod=0, counter=0. spm_rst=0 whenever rst==0 (combinational).
//   FSM: IDLE -> CLEAR on accept. CLEAR -> RUN after 1 cycle.
//     RUN -> DONE when cnt==2*WIDTH+P_LAT-1.
//     DONE -> IDLE on prod_ready without start_valid.
//     DONE -> CLEAR on prod_ready && start_valid (back-to-back).
//   start_ready = (IDLE) | (DONE & prod_ready); never high in CLEAR/RUN.
//   Accept latches a_in->spm_x and b_in->shift reg. Later a_in/b_in changes are ignored.
//   CLEAR: spm_rst=0 for exactly 1 cycle; spm_y=0; prod cleared to 0.
//   RUN: cnt runs 0..2*WIDTH+P_LAT-1 (width $clog2(2*WIDTH+P_LAT)); spm_rst=1.
//     spm_y = b[cnt] for cnt<WIDTH; sign/zero per SIGNED for WIDTH<=cnt<2*WIDTH; else 0.
//     When cnt>=P_LAT: spm_p sampled at the edge into prod[cnt-P_LAT]
//       (right-shift into prod MSB; final prod LSB = first sampled bit).
//     Product arithmetic: unsigned, or two's complement when SIGNED=1; result modulo 2^(2*WIDTH).
//   DONE: prod_valid=1 and prod held stable until the handshake; spm_y=0, spm_rst=1.
//   Latency: accept at edge E0 -> prod_valid first high in cycle 2*WIDTH+P_LAT+2 after E0.
//     67 cycles at the defaults.
//   Reset mid-CLEAR/RUN/DONE: the operation is abandoned and no prod_valid follows.
//     Next accept starts clean.
//   prod_ready while !prod_valid: ignored. start_valid while busy (not DONE&prod_ready): stalls.
// TESTING
//   1. WIDTH=32, a=3, b=5, prod_ready=1 -> prod=64'h0F, prod_valid at cycle 67 for 1 cycle.
//   2. a=b=32'hFFFF_FFFF, SIGNED=0 -> prod=64'hFFFF_FFFE_0000_0001.
//   3. SIGNED=1, a=3, b=32'hFFFF_FFFF -> prod=64'hFFFF_FFFF_FFFF_FFFD.
//   4. prod_ready=0 for 10 cycles after prod_valid -> prod and prod_valid stable, start_ready=0.
//      Then 1 -> IDLE.
//   5. Back-to-back: start_valid held with pair 2 during DONE & prod_ready
//      -> CLEAR next cycle, no IDLE gap.
//      Check spm_rst low exactly 1 cycle per op.
//   6. rst=0 at RUN cnt=20 -> next cycle IDLE, spm_rst=0, no prod_valid.
//      A fresh 7*9 then yields 63.

Source files
------------

// File: rtl/spm_seq_ctrl_if.sv
// rtl/spm_seq_ctrl_if.sv - operand/product handshake and spm array bus for spm_seq_ctrl
//
// Purpose: bundles the host-side operand and product handshakes with the
// serial-parallel multiplier array connection.
// Signals:
//   start_valid/start_ready  operand pair handshake (a_in multiplicand, b_in multiplier)
//   prod/prod_valid/prod_ready  2*WIDTH-bit product handshake
//   busy                     sequencer not idle
//   spm_x/spm_y/spm_rst/spm_p  parallel x, serial y, active-low csa clear, serial product
// Modports: slave = sequencer side, master = host/array side.

interface spm_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 start_valid;
  logic                 start_ready;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic [WIDTH-1:0]     spm_x;
  logic                 spm_y;
  logic                 spm_rst;
  logic                 spm_p;
  logic [2*WIDTH-1:0]   prod;
  logic                 prod_valid;
  logic                 prod_ready;
  logic                 busy;

  modport slave (
    input  start_valid, a_in, b_in, spm_p, prod_ready,
    output start_ready, spm_x, spm_y, spm_rst, prod, prod_valid, busy
  );

  modport master (
    output start_valid, a_in, b_in, spm_p, prod_ready,
    input  start_ready, spm_x, spm_y, spm_rst, prod, prod_valid, busy
  );
endinterface

// File: rtl/spm_seq_ctrl.sv
// rtl/spm_seq_ctrl.sv - sequencer driving a serial-parallel multiplier array
//
// Purpose: accepts an operand pair, clears the spm csa state for one cycle,
// streams the multiplier LSB-first (sign or zero extended to 2*WIDTH bits),
// deserialises the product bits returned by the array and presents the
// 2*WIDTH-bit product until it is consumed.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-low (also forces spm_rst low combinationally)
//   bus   spm_seq_ctrl_if.slave: operand/product handshakes and spm array signals

module spm_seq_ctrl #(
  parameter int WIDTH  = 32,
  parameter int P_LAT  = 1,
  parameter bit SIGNED = 1'b0
) (
  input logic            clk,
  input logic            rst,
  spm_seq_ctrl_if.slave  bus
);

  localparam int CW = $clog2(2*WIDTH + P_LAT);
  localparam logic [CW-1:0] CNT_LAST    = CW'(2*WIDTH + P_LAT - 1);
  localparam logic [CW-1:0] CNT_Y_END   = CW'(2*WIDTH);
  localparam logic [CW-1:0] CNT_P_START = CW'(P_LAT);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 start_ready;

  // DONE can hand over directly to a new operation when the product is consumed.
  assign start_ready = (state_q == IDLE) || ((state_q == DONE) && bus.prod_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    b_d     = b_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          state_d = CLEAR;
          x_d     = bus.a_in;
          b_d     = bus.b_in;
        end
      end
      CLEAR: begin
        state_d = RUN;
        cnt_d   = '0;
        prod_d  = '0;
      end
      RUN: begin
        // Arithmetic/logical right shift: once the original bits are used up,
        // b_q[0] keeps presenting the extension bit.
        b_d = {SIGNED & b_q[WIDTH-1], b_q[WIDTH-1:1]};
        // Array output lags y by P_LAT; shifting in at the MSB leaves the
        // first sampled bit at the LSB after 2*WIDTH samples.
        if (cnt_q >= CNT_P_START) begin
          prod_d = {bus.spm_p, prod_q[2*WIDTH-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.prod_ready) begin
          if (bus.start_valid) begin
            state_d = CLEAR;
            x_d     = bus.a_in;
            b_d     = bus.b_in;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.start_ready = start_ready;
  assign bus.spm_x       = x_q;
  assign bus.spm_y       = ((state_q == RUN) && (cnt_q < CNT_Y_END)) ? b_q[0] : 1'b0;
  assign bus.spm_rst     = rst && (state_q != CLEAR);
  assign bus.prod        = prod_q;
  assign bus.prod_valid  = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// tb/tb_spm_seq_ctrl.sv - directed bench for spm_seq_ctrl with behavioural spm arrays

module tb_spm_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  spm_seq_ctrl_if #(.WIDTH(32)) ifu ();
  spm_seq_ctrl_if #(.WIDTH(32)) ifs ();

  spm_seq_ctrl #(.WIDTH(32), .P_LAT(1), .SIGNED(1'b0)) u_dut_u (
    .clk (clk),
    .rst (rst),
    .bus (ifu)
  );

  spm_seq_ctrl #(.WIDTH(32), .P_LAT(1), .SIGNED(1'b1)) u_dut_s (
    .clk (clk),
    .rst (rst),
    .bus (ifs)
  );

  // Behavioural spm array: product bit k appears one cycle after y bit k.
  function automatic logic p_bit(input logic [63:0] x, input logic [63:0] yacc,
                                 input logic y, input int k);
    logic [63:0] ynew;
    logic [63:0] pr;
    ynew = yacc | ({63'b0, y} << k);
    pr   = x * ynew;
    return pr[k];
  endfunction

  int          ku, ks;
  logic [63:0] yu, ys;
  logic        pu, ps;

  always @(posedge clk) begin
    if (!ifu.spm_rst) begin
      ku <= 0; yu <= '0; pu <= 1'b0;
    end else if (ku < 64) begin
      yu <= yu | ({63'b0, ifu.spm_y} << ku);
      pu <= p_bit({32'b0, ifu.spm_x}, yu, ifu.spm_y, ku);
      ku <= ku + 1;
    end else begin
      pu <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!ifs.spm_rst) begin
      ks <= 0; ys <= '0; ps <= 1'b0;
    end else if (ks < 64) begin
      ys <= ys | ({63'b0, ifs.spm_y} << ks);
      ps <= p_bit({{32{ifs.spm_x[31]}}, ifs.spm_x}, ys, ifs.spm_y, ks);
      ks <= ks + 1;
    end else begin
      ps <= 1'b0;
    end
  end

  assign ifu.spm_p = pu;
  assign ifs.spm_p = ps;

  task automatic drive(input logic sv, input logic [31:0] a, input logic [31:0] b, input logic pr);
    ifu.start_valid = sv; ifs.start_valid = sv;
    ifu.a_in = a;         ifs.a_in = a;
    ifu.b_in = b;         ifs.b_in = b;
    ifu.prod_ready = pr;  ifs.prod_ready = pr;
  endtask

  // Offers a pair, waits for acceptance edge E0, returns at the negedge of cycle 1
  // with the operand bus scrambled so later changes must be ignored.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    drive(1'b1, a, b, ifu.prod_ready);
    while (!ifu.start_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, $urandom, $urandom, ifu.prod_ready);
  endtask

  // Called at the cycle-1 negedge; returns the cycle index of the first prod_valid
  // (200 on timeout) and how many cycles spm_rst was low before it.
  task automatic wait_valid(output int cyc, output int rst_lo);
    cyc = 1;
    rst_lo = 0;
    while (!ifu.prod_valid && cyc < 200) begin
      if (!ifu.spm_rst) rst_lo++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ifu.start_ready !== 1'b1) $display("FAIL reset_start_ready got %b exp 1", ifu.start_ready); else n_pass++;
    n_checks++; if (ifu.prod_valid !== 1'b0) $display("FAIL reset_prod_valid got %b exp 0", ifu.prod_valid); else n_pass++;
    n_checks++; if (ifu.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", ifu.busy); else n_pass++;
    n_checks++; if (ifu.spm_y !== 1'b0) $display("FAIL reset_spm_y got %b exp 0", ifu.spm_y); else n_pass++;
    n_checks++; if (ifu.spm_x !== 32'h0) $display("FAIL reset_spm_x got %h exp 0", ifu.spm_x); else n_pass++;
    n_checks++; if (ifu.prod !== 64'h0) $display("FAIL reset_prod got %h exp 0", ifu.prod); else n_pass++;
    n_checks++; if (ifu.spm_rst !== 1'b0) $display("FAIL reset_spm_rst got %b exp 0", ifu.spm_rst); else n_pass++;
    n_checks++; if (ifs.busy !== 1'b0) $display("FAIL reset_busy_s got %b exp 0", ifs.busy); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (ifu.spm_rst !== 1'b1) $display("FAIL reset_release_spm_rst got %b exp 1", ifu.spm_rst); else n_pass++;
  endtask

  task automatic test_basic;
    int cyc, lo;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    start_op(32'd3, 32'd5);
    n_checks++; if (ifu.start_ready !== 1'b0) $display("FAIL basic_clear_start_ready got %b exp 0", ifu.start_ready); else n_pass++;
    n_checks++; if (ifu.spm_x !== 32'd3) $display("FAIL basic_spm_x got %h exp 3", ifu.spm_x); else n_pass++;
    wait_valid(cyc, lo);
    n_checks++; if (cyc !== 67) $display("FAIL basic_latency got %0d exp 67", cyc); else n_pass++;
    n_checks++; if (lo !== 1) $display("FAIL basic_spm_rst_low got %0d exp 1", lo); else n_pass++;
    n_checks++; if (ifu.prod !== 64'h0F) $display("FAIL basic_prod got %h exp %h", ifu.prod, 64'h0F); else n_pass++;
    n_checks++; if (ifs.prod !== 64'h0F) $display("FAIL basic_prod_s got %h exp %h", ifs.prod, 64'h0F); else n_pass++;
    @(negedge clk);
    n_checks++; if (ifu.prod_valid !== 1'b0) $display("FAIL basic_valid_one_cycle got %b exp 0", ifu.prod_valid); else n_pass++;
    n_checks++; if (ifu.busy !== 1'b0) $display("FAIL basic_idle got %b exp 0", ifu.busy); else n_pass++;
  endtask

  task automatic test_max;
    int cyc, lo;
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(cyc, lo);
    n_checks++; if (ifu.prod !== 64'hFFFF_FFFE_0000_0001) $display("FAIL max_prod got %h exp %h", ifu.prod, 64'hFFFF_FFFE_0000_0001); else n_pass++;
    n_checks++; if (ifs.prod !== 64'h1) $display("FAIL max_prod_s got %h exp %h", ifs.prod, 64'h1); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_signed;
    int cyc, lo;
    start_op(32'd3, 32'hFFFF_FFFF);
    wait_valid(cyc, lo);
    n_checks++; if (ifs.prod !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL signed_prod got %h exp %h", ifs.prod, 64'hFFFF_FFFF_FFFF_FFFD); else n_pass++;
    n_checks++; if (ifu.prod !== 64'h0000_0002_FFFF_FFFD) $display("FAIL signed_prod_u got %h exp %h", ifu.prod, 64'h0000_0002_FFFF_FFFD); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_hold;
    int cyc, lo;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    start_op(32'h0001_0001, 32'h0000_0100);
    wait_valid(cyc, lo);
    n_checks++; if (cyc !== 67) $display("FAIL hold_latency got %0d exp 67", cyc); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (ifu.prod_valid !== 1'b1) $display("FAIL hold_valid[%0d] got %b exp 1", i, ifu.prod_valid); else n_pass++;
      n_checks++; if (ifu.prod !== 64'h0100_0100) $display("FAIL hold_prod[%0d] got %h exp %h", i, ifu.prod, 64'h0100_0100); else n_pass++;
      n_checks++; if (ifu.start_ready !== 1'b0) $display("FAIL hold_start_ready[%0d] got %b exp 0", i, ifu.start_ready); else n_pass++;
      @(negedge clk);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    n_checks++; if (ifu.start_ready !== 1'b1) $display("FAIL hold_release_ready got %b exp 1", ifu.start_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (ifu.busy !== 1'b0) $display("FAIL hold_idle got %b exp 0", ifu.busy); else n_pass++;
    n_checks++; if (ifu.prod_valid !== 1'b0) $display("FAIL hold_valid_drop got %b exp 0", ifu.prod_valid); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int cyc, lo;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    start_op(32'd7, 32'd6);
    wait_valid(cyc, lo);
    n_checks++; if (lo !== 1) $display("FAIL b2b_op1_spm_rst_low got %0d exp 1", lo); else n_pass++;
    n_checks++; if (ifu.prod !== 64'd42) $display("FAIL b2b_op1_prod got %h exp %h", ifu.prod, 64'd42); else n_pass++;
    drive(1'b1, 32'd9, 32'd11, 1'b1);
    #1;
    n_checks++; if (ifu.start_ready !== 1'b1) $display("FAIL b2b_start_ready got %b exp 1", ifu.start_ready); else n_pass++;
    @(negedge clk);
    drive(1'b0, $urandom, $urandom, 1'b1);
    n_checks++; if (ifu.busy !== 1'b1) $display("FAIL b2b_no_idle_gap got %b exp 1", ifu.busy); else n_pass++;
    n_checks++; if (ifu.prod_valid !== 1'b0) $display("FAIL b2b_valid_drop got %b exp 0", ifu.prod_valid); else n_pass++;
    n_checks++; if (ifu.spm_x !== 32'd9) $display("FAIL b2b_spm_x got %h exp 9", ifu.spm_x); else n_pass++;
    wait_valid(cyc, lo);
    n_checks++; if (cyc !== 67) $display("FAIL b2b_latency got %0d exp 67", cyc); else n_pass++;
    n_checks++; if (lo !== 1) $display("FAIL b2b_op2_spm_rst_low got %0d exp 1", lo); else n_pass++;
    n_checks++; if (ifu.prod !== 64'd99) $display("FAIL b2b_op2_prod got %h exp %h", ifu.prod, 64'd99); else n_pass++;
    n_checks++; if (ifs.prod !== 64'd99) $display("FAIL b2b_op2_prod_s got %h exp %h", ifs.prod, 64'd99); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc, lo, seen;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    start_op(32'h55, 32'h77);
    repeat (21) @(negedge clk);
    n_checks++; if (ifu.busy !== 1'b1) $display("FAIL mid_busy_before got %b exp 1", ifu.busy); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (ifu.busy !== 1'b0) $display("FAIL mid_idle got %b exp 0", ifu.busy); else n_pass++;
    n_checks++; if (ifu.spm_rst !== 1'b0) $display("FAIL mid_spm_rst got %b exp 0", ifu.spm_rst); else n_pass++;
    n_checks++; if (ifu.prod_valid !== 1'b0) $display("FAIL mid_prod_valid got %b exp 0", ifu.prod_valid); else n_pass++;
    n_checks++; if (ifu.prod !== 64'h0) $display("FAIL mid_prod got %h exp 0", ifu.prod); else n_pass++;
    n_checks++; if (ifu.spm_x !== 32'h0) $display("FAIL mid_spm_x got %h exp 0", ifu.spm_x); else n_pass++;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ifu.prod_valid) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL mid_no_prod_valid got %0d exp 0", seen); else n_pass++;
    start_op(32'd7, 32'd9);
    wait_valid(cyc, lo);
    n_checks++; if (cyc !== 67) $display("FAIL mid_fresh_latency got %0d exp 67", cyc); else n_pass++;
    n_checks++; if (ifu.prod !== 64'd63) $display("FAIL mid_fresh_prod got %h exp %h", ifu.prod, 64'd63); else n_pass++;
    n_checks++; if (ifs.prod !== 64'd63) $display("FAIL mid_fresh_prod_s got %h exp %h", ifs.prod, 64'd63); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_signed();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
